// File: rtl/test_ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// test_ram_req_ctrl
//
// Request sequencer sitting directly in front of TestRam. It takes one CPU
// load/store at a time over a ready/valid handshake, presents it to TestRam
// as a single-cycle access, and then waits for the RAM's registered read
// latency plus WAIT_STATES extra cycles. After that it returns the
// size-formatted read data as a one-cycle response pulse.
//
// Parameters
//   WAIT_STATES  extra cycles between the RAM access and the response (0..15)
//   ADDR_WIDTH   CPU-side address width; the address reaches TestRam unmasked
//
// Ports
//   clk            system clock, every flop on posedge
//   rst            synchronous reset, active-high
//   req_valid      CPU request present
//   req_ready      controller idle and able to accept a request
//   req_write      1 = store, 0 = load
//   req_size       pkg_cpu::ReqDataSz encoding (8/16/32/48 bits)
//   req_addr       byte address, any alignment
//   req_wdata      store data, right-justified
//   rsp_valid      one-cycle response pulse
//   rsp_was_write  the response belongs to a store
//   rsp_rdata      load data, right-justified and zero-extended
//   ram_req        TestRam request struct {addr, data, req_write, req_data_size}
//   ram_data_out   TestRam registered read data; the byte at addr is in [47:40]
// ---------------------------------------------------------------------------

package pkg_cpu;
  typedef enum logic [1:0] {
    ReqDataSz8  = 2'd0,
    ReqDataSz16 = 2'd1,
    ReqDataSz32 = 2'd2,
    ReqDataSz48 = 2'd3
  } ReqDataSz;
endpackage

package pkg_testing;
  typedef struct packed {
    logic [31:0]       addr;
    logic [47:0]       data;
    logic              req_write;
    pkg_cpu::ReqDataSz req_data_size;
  } StrcInTestRam;
endpackage

module test_ram_req_ctrl #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [47:0]               req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_was_write,
  output logic [47:0]               rsp_rdata,
  output pkg_testing::StrcInTestRam ram_req,
  input  logic [47:0]               ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] wait_cnt;
  // ram_req.req_write only stays high for the ACCESS cycle. This flop keeps
  // the request type so the response can still report it later.
  logic       wr_q;

  // The RAM returns big-endian data with the addressed byte at the top.
  // Loads take the leading bytes and right-justify them.
  function automatic logic [47:0] fmt_load(input pkg_cpu::ReqDataSz sz,
                                           input logic [47:0]       d);
    logic [47:0] r;
    case (sz)
      pkg_cpu::ReqDataSz8:  r = {40'b0, d[47:40]};
      pkg_cpu::ReqDataSz16: r = {32'b0, d[47:32]};
      pkg_cpu::ReqDataSz32: r = {16'b0, d[47:16]};
      default:              r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_was_write <= 1'b0;
      rsp_rdata     <= '0;
      ram_req       <= '0;
      wait_cnt      <= '0;
      wr_q          <= 1'b0;
    end else begin
      case (state)
        // Accept: latch the whole request into the RAM struct. The address
        // passes through untouched because wrap/masking belongs to TestRam.
        IDLE: begin
          if (req_valid && req_ready) begin
            ram_req.addr          <= 32'(req_addr);
            ram_req.data          <= req_wdata;
            ram_req.req_write     <= req_write;
            ram_req.req_data_size <= pkg_cpu::ReqDataSz'(req_size);
            wr_q                  <= req_write;
            req_ready             <= 1'b0;
            state                 <= ACCESS;
          end
        end
        // RAM commits the store and registers the read at the end of this cycle.
        ACCESS: begin
          ram_req.req_write <= 1'b0;
          wait_cnt          <= '0;
          state             <= WAIT;
        end
        // Read data is valid from the first WAIT cycle onward, because the
        // request stays held. Capture it on the last wait cycle.
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rsp_rdata     <= wr_q ? 48'h0 : fmt_load(ram_req.req_data_size, ram_data_out);
            rsp_valid     <= 1'b1;
            rsp_was_write <= wr_q;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        // Response pulse; ready again the cycle after.
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_ram_req_ctrl.sv
module tb_test_ram_req_ctrl;
  import pkg_testing::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // lane 0: WAIT_STATES=0, lane 1: WAIT_STATES=3
  logic         rst           [2];
  logic         req_valid     [2];
  logic         req_ready     [2];
  logic         req_write     [2];
  logic [1:0]   req_size      [2];
  logic [31:0]  req_addr      [2];
  logic [47:0]  req_wdata     [2];
  logic         rsp_valid     [2];
  logic         rsp_was_write [2];
  logic [47:0]  rsp_rdata     [2];
  StrcInTestRam ram_req       [2];
  logic [47:0]  ram_data_out  [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit clr      = 1'b1;
  bit ck_en    = 1'b0;

  test_ram_req_ctrl #(.WAIT_STATES(0), .ADDR_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_was_write(rsp_was_write[0]),
    .rsp_rdata(rsp_rdata[0]), .ram_req(ram_req[0]), .ram_data_out(ram_data_out[0]));

  test_ram_req_ctrl #(.WAIT_STATES(3), .ADDR_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_was_write(rsp_was_write[1]),
    .rsp_rdata(rsp_rdata[1]), .ram_req(ram_req[1]), .ram_data_out(ram_data_out[1]));

  function automatic int ws(input int l);
    return (l == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  task automatic chk(input string nm, input int l, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, l, $time, act, exp);
    end
  endtask

  // TestRam stand-in: 16-bit real address, big-endian, registered read
  logic [7:0] ram_mem [2][65536];
  always @(posedge clk) begin
    logic [47:0] rd;
    for (int l = 0; l < 2; l++) begin
      if (clr) begin
        for (int a = 0; a < 65536; a++) ram_mem[l][a] <= 8'h00;
      end else if (ram_req[l].req_write) begin
        for (int i = 0; i < nbytes(ram_req[l].req_data_size); i++)
          ram_mem[l][16'(ram_req[l].addr + 32'(i))] <=
            ram_req[l].data[8*(nbytes(ram_req[l].req_data_size)-1-i) +: 8];
      end
      for (int j = 0; j < 6; j++) rd[47-8*j -: 8] = ram_mem[l][16'(ram_req[l].addr + 32'(j))];
      ram_data_out[l] <= rd;
    end
  end

  // Reference model: byte memory plus "cycles since accept" bookkeeping
  logic [7:0]   ref_mem  [2][65536];
  bit           busy     [2];
  int           k        [2];
  bit           m_wr     [2];
  logic [47:0]  m_load   [2];
  bit           e_ready  [2];
  bit           e_rspv   [2];
  bit           e_rspw   [2];
  logic [47:0]  e_rdata  [2];
  StrcInTestRam e_ram    [2];
  bit           e_ram_chk[2];

  function automatic logic [47:0] ref_load(input int l, input logic [31:0] a, input logic [1:0] sz);
    logic [47:0] d;
    for (int j = 0; j < 6; j++) d[47-8*j -: 8] = ref_mem[l][16'(a + 32'(j))];
    return d >> (48 - 8*nbytes(sz));
  endfunction

  task automatic ref_store(input int l, input logic [31:0] a, input logic [1:0] sz, input logic [47:0] wd);
    int nb;
    nb = nbytes(sz);
    for (int i = 0; i < nb; i++) ref_mem[l][16'(a + 32'(i))] = wd[8*(nb-1-i) +: 8];
  endtask

  // Compare at negedge, then advance the model with the inputs the next edge samples
  initial forever begin
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      if (ck_en) begin
        chk("req_ready", l, 64'(req_ready[l]), 64'(e_ready[l]));
        chk("rsp_valid", l, 64'(rsp_valid[l]), 64'(e_rspv[l]));
        chk("rsp_rdata", l, 64'(rsp_rdata[l]), 64'(e_rdata[l]));
        chk("ram_req_write", l, 64'(ram_req[l].req_write), 64'(e_ram[l].req_write));
        if (e_rspv[l]) chk("rsp_was_write", l, 64'(rsp_was_write[l]), 64'(e_rspw[l]));
        if (e_ram_chk[l]) begin
          chk("ram_addr", l, 64'(ram_req[l].addr), 64'(e_ram[l].addr));
          chk("ram_data", l, 64'(ram_req[l].data), 64'(e_ram[l].data));
          chk("ram_size", l, 64'(ram_req[l].req_data_size), 64'(e_ram[l].req_data_size));
        end
      end
      if (clr) for (int a = 0; a < 65536; a++) ref_mem[l][a] = 8'h00;
      if (rst[l]) begin
        busy[l] = 1'b0; e_ready[l] = 1'b1; e_rspv[l] = 1'b0; e_rspw[l] = 1'b0;
        e_rdata[l] = '0; e_ram[l] = '0; e_ram_chk[l] = 1'b1;
      end else begin
        if (!busy[l] && req_valid[l]) begin
          busy[l] = 1'b1;
          k[l]    = 0;
          m_wr[l] = req_write[l];
          m_load[l] = ref_load(l, req_addr[l], req_size[l]);
          if (req_write[l]) ref_store(l, req_addr[l], req_size[l], req_wdata[l]);
          e_ram[l].addr          = req_addr[l];
          e_ram[l].data          = req_wdata[l];
          e_ram[l].req_data_size = pkg_cpu::ReqDataSz'(req_size[l]);
          e_ram_chk[l] = 1'b1;
        end
        if (busy[l]) begin
          k[l]++;
          e_ram[l].req_write = m_wr[l] && (k[l] == 1);
          e_rspv[l] = (k[l] == 3 + ws(l));
          if (e_rspv[l]) begin
            e_rdata[l] = m_wr[l] ? 48'h0 : m_load[l];
            e_rspw[l]  = m_wr[l];
          end
          if (k[l] == 4 + ws(l)) begin
            busy[l] = 1'b0;
            e_ram_chk[l] = 1'b0;
          end
        end
        e_ready[l] = !busy[l];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, return cycles from accept to rsp_valid and the response
  task automatic issue(input int l, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [47:0] wd, output int lat, output logic [47:0] rd,
                       output bit rw);
    int g;
    g = 0;
    while (!req_ready[l] && g < 50) begin tick(); g++; end
    if (g >= 50) chk("ready_timeout", l, 64'(req_ready[l]), 64'd1);
    req_valid[l] = 1'b1; req_write[l] = wr; req_size[l] = sz; req_addr[l] = a; req_wdata[l] = wd;
    tick();
    req_valid[l] = 1'b0;
    lat = 1;
    while (!rsp_valid[l] && lat < 40) begin tick(); lat++; end
    if (lat >= 40) chk("rsp_timeout", l, 64'(rsp_valid[l]), 64'd1);
    rd = rsp_rdata[l];
    rw = rsp_was_write[l];
  endtask

  initial begin
    int lat;
    logic [47:0] rd;
    bit rw;
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; req_valid[l] = 1'b1; req_write[l] = 1'b1; req_size[l] = 2'd2;
      req_addr[l] = 32'h10; req_wdata[l] = 48'hBAD0BAD0; busy[l] = 1'b0; k[l] = 0;
    end
    // reset held two cycles with req_valid high
    tick(); tick();
    for (int l = 0; l < 2; l++) begin rst[l] = 1'b0; req_valid[l] = 1'b0; end
    clr = 1'b0; ck_en = 1'b1;
    tick();
    for (int l = 0; l < 2; l++) begin
      chk("rst_ready", l, 64'(req_ready[l]), 64'd1);
      chk("rst_rsp_valid", l, 64'(rsp_valid[l]), 64'd0);
      chk("rst_ram_write", l, 64'(ram_req[l].req_write), 64'd0);
    end

    // W=0: store then loads
    issue(0, 1'b1, 2'd2, 32'h0010, 48'h11223344, lat, rd, rw);
    chk("st_lat", 0, 64'(lat), 64'd3);
    chk("st_rdata", 0, 64'(rd), 64'd0);
    chk("st_was_write", 0, 64'(rw), 64'd1);
    issue(0, 1'b0, 2'd2, 32'h0010, 48'h0, lat, rd, rw);
    chk("ld32_lat", 0, 64'(lat), 64'd3);
    chk("ld32_rdata", 0, 64'(rd), 64'h0000_1122_3344);
    chk("ld32_was_write", 0, 64'(rw), 64'd0);
    issue(0, 1'b0, 2'd0, 32'h0012, 48'h0, lat, rd, rw);
    chk("ld8_rdata", 0, 64'(rd), 64'h33);
    issue(0, 1'b0, 2'd1, 32'h0011, 48'h0, lat, rd, rw);
    chk("ld16_misaligned", 0, 64'(rd), 64'h2233);
    // 48-bit store wrapping the 16-bit RAM address space
    issue(0, 1'b1, 2'd3, 32'h0000_FFFE, 48'hA1A2A3A4A5A6, lat, rd, rw);
    issue(0, 1'b0, 2'd3, 32'h0000_FFFE, 48'h0, lat, rd, rw);
    chk("ld48_wrap", 0, 64'(rd), 64'hA1A2A3A4A5A6);
    issue(0, 1'b0, 2'd0, 32'h0000_0000, 48'h0, lat, rd, rw);
    chk("ld8_wrapped_byte", 0, 64'(rd), 64'hA3);

    // W=3: latency and ignored request while busy
    issue(1, 1'b1, 2'd2, 32'h0010, 48'h11223344, lat, rd, rw);
    chk("w3_st_lat", 1, 64'(lat), 64'd6);
    tick();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 32'h10;
    tick();
    for (int c = 1; c <= 6; c++) begin
      chk("w3_busy_ready", 1, 64'(req_ready[1]), 64'd0);
      chk("w3_rsp_valid", 1, 64'(rsp_valid[1]), 64'(c == 6));
      if (c == 6) chk("w3_rdata", 1, 64'(rsp_rdata[1]), 64'h0000_1122_3344);
      if (c == 3) begin
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_size[1] = 2'd1; req_wdata[1] = 48'hDEAD;
      end else begin
        req_valid[1] = 1'b0;
      end
      tick();
    end
    chk("w3_ready_back", 1, 64'(req_ready[1]), 64'd1);
    chk("w3_no_extra_rsp", 1, 64'(rsp_valid[1]), 64'd0);

    // reset during the second WAIT cycle of a load
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 32'h10;
    tick();
    req_valid[1] = 1'b0;
    tick(); tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("abort_ready", 1, 64'(req_ready[1]), 64'd1);
    for (int c = 0; c < 8; c++) begin
      chk("abort_no_rsp", 1, 64'(rsp_valid[1]), 64'd0);
      tick();
    end
    issue(1, 1'b0, 2'd2, 32'h0010, 48'h0, lat, rd, rw);
    chk("after_abort_lat", 1, 64'(lat), 64'd6);
    chk("after_abort_rdata", 1, 64'(rd), 64'h0000_1122_3344);

    // randomized traffic around the wrap point, with occasional resets
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 700; c++) begin
        rst[l]       = ($urandom_range(0, 39) == 0);
        req_valid[l] = ($urandom_range(0, 2) != 0);
        req_write[l] = 1'($urandom_range(0, 1));
        req_size[l]  = 2'($urandom_range(0, 3));
        req_addr[l]  = {16'($urandom), 16'(32'hFFF0 + $urandom_range(0, 31))};
        req_wdata[l] = {16'($urandom), $urandom};
        tick();
      end
      rst[l] = 1'b0; req_valid[l] = 1'b0;
      repeat (25) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
